enigma_rotor_stage: RTL and testbench

Parametrised, handshaked rotor stage for the cipher datapath. It generalises the fixed 26-letter rotor in several ways: alphabet size, symbol base and step size are configurable, the wiring table is runtime-loadable, and notch carry out / step in let stages cascade. Encode is a single table lookup; decode is a sequential inverse search. The stage sits between the plugboard/input stage and the next rotor or reflector, with valid/ready on both sides.

---
 rtl/enigma_rotor_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_enigma_rotor_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_rotor_stage.sv
// -----------------------------------------------------------------------------
// enigma_rotor_stage
//
// One rotor of the cipher datapath, with valid/ready handshakes on both sides.
// The wiring table can be loaded at run time, and the alphabet size, symbol
// base and self-step are all configurable. Encode is a single table lookup.
// Decode scans the table one entry per cycle for the inverse. Stages cascade
// through the step_in / carry_out pair.
//
// Parameters:
//   ALPHA  - alphabet size (2..64)
//   IDX_W  - index width, ceil(log2(ALPHA))
//   CHAR_W - character width on in_char / out_char
//   BASE   - character code of index 0
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cfg_we/addr/data      wiring table write W[cfg_addr] = cfg_data (IDLE only)
//   cfg_pos_we/pos/step/notch
//                         load rotor position, self-step and notch (IDLE only)
//   step_in               extra +1 advance carried in from the previous stage
//   in_valid/in_ready     input handshake; in_ready is high only in IDLE
//   in_char, in_dec       input symbol and direction (1 = decode)
//   out_valid/out_ready   output handshake
//   out_char, out_err     result symbol; err = decode found no inverse
//   carry_out             one-cycle pulse after an advance from the notch
// -----------------------------------------------------------------------------
module enigma_rotor_stage #(
  parameter int ALPHA  = 26,
  parameter int IDX_W  = 5,
  parameter int CHAR_W = 8,
  parameter int BASE   = 65
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [IDX_W-1:0]  cfg_data,
  input  logic              cfg_pos_we,
  input  logic [IDX_W-1:0]  cfg_pos,
  input  logic [IDX_W-1:0]  cfg_step,
  input  logic [IDX_W-1:0]  cfg_notch,
  input  logic              step_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  input  logic              in_dec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_char,
  output logic              out_err,
  output logic              carry_out
);

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    SRCH,
    OUT
  } state_t;

  localparam logic [IDX_W:0]    ALPHA_X = (IDX_W+1)'(ALPHA);
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(ALPHA - 1);
  localparam logic [CHAR_W-1:0] BASE_C  = CHAR_W'(BASE);
  localparam logic [CHAR_W-1:0] ALPHA_C = CHAR_W'(ALPHA);

  state_t            state;
  logic [IDX_W-1:0]  w [ALPHA];
  logic [IDX_W-1:0]  pos;
  logic [IDX_W-1:0]  step;
  logic [IDX_W-1:0]  notch;

  // Per-symbol context, captured at accept time.
  logic [CHAR_W-1:0] char_q;
  logic [IDX_W-1:0]  idx_q;
  logic              pass_q;
  logic [IDX_W-1:0]  p_q;
  logic [IDX_W-1:0]  j;

  logic [CHAR_W-1:0] in_off;
  logic              in_pass;
  logic              accept;
  logic              cfg_ok;
  logic              pos_ok;
  logic [IDX_W-1:0]  pos_next;
  logic              pos_adv;

  // (a + b + c) mod ALPHA. Both operands are already below ALPHA, so one
  // conditional subtraction is enough (the sum is at most 2*ALPHA-1).
  function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b,
                                               input logic             c);
    logic [IDX_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{IDX_W{1'b0}}, c};
    if (sum >= ALPHA_X) sum = sum - ALPHA_X;
    return sum[IDX_W-1:0];
  endfunction

  // (a - b) mod ALPHA. The subtraction is done as a + ALPHA - b so that it
  // never goes negative.
  function automatic logic [IDX_W-1:0] mod_sub(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    logic [IDX_W:0] diff;
    diff = {1'b0, a} + ALPHA_X - {1'b0, b};
    if (diff >= ALPHA_X) diff = diff - ALPHA_X;
    return diff[IDX_W-1:0];
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // The unsigned wrap sends characters below BASE into the passthrough range.
  assign in_off  = in_char - BASE_C;
  assign in_pass = (in_off >= ALPHA_C);

  // Writes with any out-of-range field are dropped entirely.
  assign cfg_ok = cfg_we && in_ready && (cfg_addr <= LAST) && (cfg_data <= LAST);
  assign pos_ok = cfg_pos_we && in_ready && (cfg_pos <= LAST) &&
                  (cfg_step <= LAST) && (cfg_notch <= LAST);

  // A coded symbol self-steps and absorbs any carry. Otherwise, including a
  // passthrough accept, only the carry from the previous stage advances pos.
  always_comb begin
    pos_next = pos;
    pos_adv  = 1'b0;
    if (accept && !in_pass) begin
      pos_next = mod_add(pos, step, step_in);
      pos_adv  = 1'b1;
    end else if (step_in) begin
      pos_next = mod_add(pos, '0, 1'b1);
      pos_adv  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ALPHA; i++) w[i] <= IDX_W'(i);
    end else if (cfg_ok) begin
      w[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pos       <= '0;
      step      <= IDX_W'(1);
      notch     <= LAST;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= '0;
      out_err   <= 1'b0;
      char_q    <= '0;
      idx_q     <= '0;
      pass_q    <= 1'b0;
      p_q       <= '0;
      j         <= '0;
    end else begin
      carry_out <= 1'b0;

      // A position load overrides the advance in the same cycle. A symbol
      // accepted in that cycle still uses the old pos, latched below.
      if (pos_ok) begin
        pos   <= cfg_pos;
        step  <= cfg_step;
        notch <= cfg_notch;
      end else if (pos_adv) begin
        pos       <= pos_next;
        carry_out <= (pos == notch);
      end

      case (state)
        IDLE: begin
          if (accept) begin
            char_q <= in_char;
            idx_q  <= in_off[IDX_W-1:0];
            pass_q <= in_pass;
            p_q    <= pos;
            j      <= '0;
            state  <= (in_dec && !in_pass) ? SRCH : ENC;
          end
        end

        ENC: begin
          if (pass_q) begin
            out_char <= char_q;
          end else begin
            out_char <= CHAR_W'(w[mod_add(idx_q, p_q, 1'b0)]) + BASE_C;
          end
          out_err   <= 1'b0;
          out_valid <= 1'b1;
          state     <= OUT;
        end

        // Scanning from j = 0 upward makes the lowest index win when the
        // table holds duplicates.
        SRCH: begin
          if (w[j] == idx_q) begin
            out_char  <= CHAR_W'(mod_sub(j, p_q)) + BASE_C;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (j == LAST) begin
            out_char  <= char_q;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            j <= j + IDX_W'(1);
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// -----------------------------------------------------------------------------
// tb_enigma_rotor_stage
//
// Self-checking bench for enigma_rotor_stage with the default parameters
// (26 letters, base 'A'). Symbol vectors live in a table of records. Each
// accepted symbol pushes its expected result into a scoreboard queue, and the
// entry is popped when the stage presents its output. Backpressure, carry and
// mid-search reset are handled as hand-written sequences.
// -----------------------------------------------------------------------------
module tb_enigma_rotor_stage;

  localparam int ALPHA  = 26;
  localparam int IDX_W  = 5;
  localparam int CHAR_W = 8;
  localparam int BASE   = 65;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [IDX_W-1:0]  cfg_addr = '0;
  logic [IDX_W-1:0]  cfg_data = '0;
  logic              cfg_pos_we = 1'b0;
  logic [IDX_W-1:0]  cfg_pos = '0;
  logic [IDX_W-1:0]  cfg_step = '0;
  logic [IDX_W-1:0]  cfg_notch = '0;
  logic              step_in = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CHAR_W-1:0] in_char = '0;
  logic              in_dec = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CHAR_W-1:0] out_char;
  logic              out_err;
  logic              carry_out;

  enigma_rotor_stage #(
    .ALPHA(ALPHA), .IDX_W(IDX_W), .CHAR_W(CHAR_W), .BASE(BASE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_pos_we(cfg_pos_we), .cfg_pos(cfg_pos), .cfg_step(cfg_step),
    .cfg_notch(cfg_notch), .step_in(step_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_dec(in_dec),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_err(out_err), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dec;
    logic [7:0]  ch;
    logic        sin;
    logic [7:0]  exp_ch;
    logic        exp_err;
    int          exp_lat;
    logic        exp_carry;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_char[$];
  logic       sb_err[$];
  int         vectors = 0;
  int         miscompares = 0;

  function automatic vec_t mk(input logic dec, input logic [7:0] ch, input logic sin,
                              input logic [7:0] exp_ch, input logic exp_err,
                              input int exp_lat, input logic exp_carry);
    vec_t v;
    v.dec = dec; v.ch = ch; v.sin = sin; v.exp_ch = exp_ch;
    v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_carry = exp_carry;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: out_valid never rose within the cycle budget", name);
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(addr);
    cfg_data = IDX_W'(data);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic cfg_pos_load(input int p, input int s, input int n);
    cfg_pos_we = 1'b1;
    cfg_pos    = IDX_W'(p);
    cfg_step   = IDX_W'(s);
    cfg_notch  = IDX_W'(n);
    @(negedge clk);
    cfg_pos_we = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Latency counts rising edges from the accept edge (inclusive) up to the
  // edge after which out_valid is visible.
  task automatic apply_stimulus(input int n, input vec_t v);
    int         edges;
    logic [7:0] exp_c;
    logic       exp_e;
    string      tag;
    tag = $sformatf("vec%0d", n);
    check_output({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_char  = v.ch;
    in_dec   = v.dec;
    step_in  = v.sin;
    @(posedge clk);
    sb_char.push_back(v.exp_ch);
    sb_err.push_back(v.exp_err);
    @(negedge clk);
    in_valid = 1'b0;
    step_in  = 1'b0;
    edges    = 1;
    check_output({tag, " carry_out"}, 32'(carry_out), 32'(v.exp_carry));
    while (!out_valid && edges < 200) begin
      @(negedge clk);
      edges++;
      if (edges == 2) check_output({tag, " carry_out width"}, 32'(carry_out), 32'd0);
    end
    exp_c = sb_char.pop_front();
    exp_e = sb_err.pop_front();
    if (!out_valid) begin
      timeout_fail(tag);
      return;
    end
    check_output({tag, " out_char"}, 32'(out_char), 32'(exp_c));
    check_output({tag, " out_err"}, 32'(out_err), 32'(exp_e));
    if (v.exp_lat > 0) check_output({tag, " latency"}, edges, v.exp_lat);
    @(negedge clk);
    check_output({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_vectors(input int first, input int last);
    for (int i = first; i <= last; i++) apply_stimulus(i, vecs[i]);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string      rotor;
    int         edges;
    logic [7:0] exp_c;
    logic       exp_e;

    rotor = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

    // identity table, pos 0, step 1
    vecs.push_back(mk(0, "A", 0, "A", 0, 2, 0));   // 0
    vecs.push_back(mk(0, "A", 0, "B", 0, 2, 0));   // 1
    vecs.push_back(mk(0, "A", 0, "C", 0, 2, 0));   // 2
    vecs.push_back(mk(0, "A", 0, "D", 0, 2, 0));   // 3  shows pos reached 3
    // rotor I wiring, pos 0
    vecs.push_back(mk(0, "A", 0, "E", 0, 2, 0));   // 4
    vecs.push_back(mk(0, "A", 0, "K", 0, 2, 0));   // 5
    // pos reloaded to 0, decode
    vecs.push_back(mk(1, "E", 0, "A", 0, 2, 0));   // 6  j=0
    vecs.push_back(mk(1, "K", 0, "A", 0, 3, 0));   // 7  j=1
    vecs.push_back(mk(1, "M", 0, "A", 0, 4, 0));   // 8  j=2
    vecs.push_back(mk(1, "A", 0, "R", 0, 22, 0));  // 9  j=20, p=3
    vecs.push_back(mk(0, "C", 0, "D", 0, 2, 0));   // 10 p=4 -> W[6]
    // notch=2, pos=2
    vecs.push_back(mk(0, "A", 0, "M", 0, 2, 1));   // 11 carry, pos->3
    vecs.push_back(mk(0, "A", 0, "F", 0, 2, 0));   // 12 W[3], pos->4
    vecs.push_back(mk(0, "A", 1, "M", 0, 2, 1));   // 13 carry with step_in, pos->4
    vecs.push_back(mk(0, "A", 0, "L", 0, 2, 0));   // 14 W[4], pos->5
    // after the backpressure sequence (which encodes at pos 5)
    vecs.push_back(mk(0, "A", 0, "D", 0, 2, 0));   // 15 W[6], pos->7
    vecs.push_back(mk(0, 8'h35, 0, 8'h35, 0, 2, 0)); // 16 '5' passthrough
    vecs.push_back(mk(0, 8'h5B, 0, 8'h5B, 0, 2, 0)); // 17 '[' passthrough
    vecs.push_back(mk(1, 8'h5B, 0, 8'h5B, 0, 2, 0)); // 18 decode passthrough
    vecs.push_back(mk(0, "A", 0, "Q", 0, 2, 0));   // 19 W[7], pos unchanged
    // identity with W[1]=0
    vecs.push_back(mk(1, "B", 0, "B", 1, ALPHA + 1, 0)); // 20 no inverse
    vecs.push_back(mk(1, "A", 0, "Z", 0, 2, 0));   // 21 lowest j=0, p=1 wraps
    // after mid-search reset
    vecs.push_back(mk(0, "C", 0, "C", 0, 2, 0));   // 22
    vecs.push_back(mk(0, "A", 0, "B", 0, 2, 0));   // 23 W[1] back to identity

    // reset state
    @(negedge clk);
    @(negedge clk);
    check_output("reset in_ready", 32'(in_ready), 32'd1);
    check_output("reset out_valid", 32'(out_valid), 32'd0);
    check_output("reset out_char", 32'(out_char), 32'd0);
    check_output("reset out_err", 32'(out_err), 32'd0);
    check_output("reset carry_out", 32'(carry_out), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_vectors(0, 3);

    // load rotor I, then an out-of-range write that must be ignored
    for (int i = 0; i < rotor.len(); i++) cfg_write(i, int'(rotor[i]) - BASE);
    cfg_write(0, 31);
    cfg_pos_load(0, 1, 25);
    run_vectors(4, 5);
    cfg_pos_load(0, 1, 25);
    run_vectors(6, 10);

    cfg_pos_load(2, 1, 2);
    run_vectors(11, 12);
    cfg_pos_load(2, 1, 2);
    run_vectors(13, 14);

    // backpressure: encode 'A' at pos 5 -> W[5] = 'G'
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_char   = "A";
    in_dec    = 1'b0;
    @(posedge clk);
    sb_char.push_back("G");
    sb_err.push_back(1'b0);
    @(negedge clk);
    in_char = "B";
    edges = 1;
    while (!out_valid && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    exp_c = sb_char.pop_front();
    exp_e = sb_err.pop_front();
    if (!out_valid) begin
      timeout_fail("backpressure");
    end else begin
      for (int k = 0; k < 5; k++) begin
        check_output($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
        check_output($sformatf("hold%0d out_char", k), 32'(out_char), 32'(exp_c));
        check_output($sformatf("hold%0d out_err", k), 32'(out_err), 32'(exp_e));
        check_output($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
        @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_output("release in_ready same cycle", 32'(in_ready), 32'd0);
      @(negedge clk);
      check_output("release in_ready next cycle", 32'(in_ready), 32'd1);
      check_output("release out_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;

    run_vectors(15, 19);

    // duplicate table entries: identity with W[1] = 0
    do_reset();
    cfg_write(1, 0);
    run_vectors(20, 21);

    // reset while searching: decode 'Z' at pos 2 scans toward j=25
    in_valid = 1'b1;
    in_char  = "Z";
    in_dec   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_dec   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("search in progress out_valid", 32'(out_valid), 32'd0);
    check_output("search in progress in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check_output("mid-search reset out_valid", 32'(out_valid), 32'd0);
    check_output("mid-search reset in_ready", 32'(in_ready), 32'd1);
    check_output("mid-search reset out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_vectors(22, 23);

    repeat (3) @(negedge clk);
    check_output("no stray output", 32'(out_valid), 32'd0);
    check_output("scoreboard empty", sb_char.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
